gppcu_rr_arbiter: RTL and testbench

- Round-robin arbiter sharing one GPPCU resource (e.g. a lane bus or memory port) among `1 << EBW` requesters.
- Picks one requester and holds a registered one-hot grant plus its binary index until the resource reports completion.
- Rotates priority after every completion.
- Sits between the requester array and the shared resource. The one-hot grant is decoded internally from the registered index.

---
 rtl/gppcu_rr_arbiter.sv | 146 ++++++++++++++
 tb/tb_gppcu_rr_arbiter.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/gppcu_rr_arbiter.sv
// gppcu_rr_arbiter
// Round-robin arbiter sharing one resource among 1 << EBW requesters.
// A grant is held until DONE; priority rotates past the finished requester
// and the next grant is chosen on the same edge, so there is no idle bubble.
//
// Optional feature macro: GPPCU_ARB_TIMEOUT_EN
//   defined   -> a grant held TMO_CYCLES edges without DONE is forcibly
//                released and TMO pulses for one cycle
//   undefined -> grants are held until DONE, TMO is tied low
//
// state | meaning
// IDLE  | no grant active, waiting for any REQ bit
// BUSY  | grant held on GNT_IDX until DONE (or timeout)

module gppcu_rr_arbiter #(
    parameter int EBW        = 2,
    parameter int TMO_CYCLES = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [(1<<EBW)-1:0]   REQ,
    input  logic                  DONE,
    output logic [(1<<EBW)-1:0]   GNT,
    output logic [EBW-1:0]        GNT_IDX,
    output logic                  GNT_VALID,
    output logic                  TMO
);

    localparam int IBW = 1 << EBW;

    // Timeouts shorter than two cycles would collide with the minimum grant.
    if (TMO_CYCLES < 2) begin : g_bad_tmo
        $error("gppcu_rr_arbiter: TMO_CYCLES must be at least 2");
    end

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t           state;
    logic [EBW-1:0]   ptr;
    logic [EBW-1:0]   gnt_idx;
    logic [EBW-1:0]   rel_base;
    logic [EBW-1:0]   pick_base;
    logic [EBW-1:0]   pick_idx;
    logic             any_req;
    logic             expire;
    logic             release_now;

    // First set request bit scanning base, base+1, ... with natural wrap.
    // Iterating from the farthest offset down leaves the nearest hit.
    function automatic logic [EBW-1:0] rr_pick(input logic [IBW-1:0] req,
                                               input logic [EBW-1:0] base);
        logic [EBW-1:0] idx;
        rr_pick = base;
        for (int i = IBW - 1; i >= 0; i--) begin
            idx = base + EBW'(i);
            if (req[idx]) begin
                rr_pick = idx;
            end
        end
    endfunction

`ifdef GPPCU_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TMO_CYCLES + 1);

    logic [CW-1:0] tmo_cnt;
    logic          tmo_q;

    // Expiry fires on the TMO_CYCLES-th BUSY edge; DONE on that edge wins.
    always_comb begin
        expire = (state == BUSY) && !DONE && (tmo_cnt == CW'(TMO_CYCLES - 1));
    end

    // Grant-age counter and the one-cycle forced-release pulse.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            tmo_cnt <= '0;
            tmo_q   <= 1'b0;
        end else begin
            tmo_q <= expire;
            if (state == IDLE || release_now) begin
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
        end
    end

    assign TMO = tmo_q;
`else
    assign expire = 1'b0;
    assign TMO    = 1'b0;
`endif

    // Release base is the slot after the finishing requester, so it drops
    // to lowest priority for the same-edge re-arbitration.
    always_comb begin
        any_req     = |REQ;
        rel_base    = gnt_idx + 1'b1;
        release_now = (state == BUSY) && (DONE || expire);
        pick_base   = (state == BUSY) ? rel_base : ptr;
        pick_idx    = rr_pick(REQ, pick_base);
    end

    // Arbitration FSM: grant from IDLE, hold in BUSY, rotate on release.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= IDLE;
            ptr     <= '0;
            gnt_idx <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        gnt_idx <= pick_idx;
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    if (release_now) begin
                        ptr <= rel_base;
                        if (any_req) begin
                            gnt_idx <= pick_idx;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs come straight from registers; GNT is a decode of GNT_IDX.
    always_comb begin
        GNT_IDX   = gnt_idx;
        GNT_VALID = (state == BUSY);
        GNT       = '0;
        if (state == BUSY) begin
            GNT[gnt_idx] = 1'b1;
        end
    end

endmodule

// File: tb/tb_gppcu_rr_arbiter.sv
// Directed bench for gppcu_rr_arbiter with EBW=2, TMO_CYCLES=8.
module tb_gppcu_rr_arbiter;

    logic       CLK;
    logic       RST;
    logic [3:0] REQ;
    logic       DONE;
    logic [3:0] GNT;
    logic [1:0] GNT_IDX;
    logic       GNT_VALID;
    logic       TMO;

    int n_asserts = 0;
    int n_fail    = 0;

    gppcu_rr_arbiter #(
        .EBW        (2),
        .TMO_CYCLES (8)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .REQ       (REQ),
        .DONE      (DONE),
        .GNT       (GNT),
        .GNT_IDX   (GNT_IDX),
        .GNT_VALID (GNT_VALID),
        .TMO       (TMO)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic grant_is(input string tag, input logic [1:0] idx, input logic [3:0] onehot);
        chk({tag, "_idx"},   {30'd0, GNT_IDX}, {30'd0, idx});
        chk({tag, "_gnt"},   {28'd0, GNT},     {28'd0, onehot});
        chk({tag, "_valid"}, {31'd0, GNT_VALID}, 32'd1);
    endtask

    // One rising edge, then back to the falling edge for checks and drives.
    task automatic step();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    initial begin
        RST  = 1'b1;
        REQ  = 4'b1111;
        DONE = 1'b0;
        step();
        step();

        // reset holds outputs low even with every request set
        chk("rst_gnt",   {28'd0, GNT},       32'd0);
        chk("rst_valid", {31'd0, GNT_VALID}, 32'd0);
        chk("rst_idx",   {30'd0, GNT_IDX},   32'd0);
        chk("rst_tmo",   {31'd0, TMO},       32'd0);

        RST = 1'b0;
        step();
        grant_is("first", 2'd0, 4'b0001);

        // rotation with continuous DONE
        DONE = 1'b1;
        step(); grant_is("rot1", 2'd1, 4'b0010);
        step(); grant_is("rot2", 2'd2, 4'b0100);
        step(); grant_is("rot3", 2'd3, 4'b1000);
        step(); grant_is("rot0", 2'd0, 4'b0001);
        step(); grant_is("rot1b", 2'd1, 4'b0010);
        step(); grant_is("rot2b", 2'd2, 4'b0100);

        // skip and wrap: PTR becomes 3, only 0 and 2 request
        REQ = 4'b0101;
        step(); grant_is("wrap0", 2'd0, 4'b0001);
        step(); grant_is("skip2", 2'd2, 4'b0100);
        REQ = 4'b0000;
        step();
        chk("drain_valid", {31'd0, GNT_VALID}, 32'd0);
        chk("drain_gnt",   {28'd0, GNT},       32'd0);
        chk("drain_idx",   {30'd0, GNT_IDX},   32'd2);

        // DONE while idle is ignored
        step();
        chk("idle_done_valid", {31'd0, GNT_VALID}, 32'd0);
        DONE = 1'b0;

        // sole requester, PTR=3: grant 2, regranted back-to-back
        REQ = 4'b0100;
        step(); grant_is("sole", 2'd2, 4'b0100);
        DONE = 1'b1;
        step(); grant_is("sole_regrant", 2'd2, 4'b0100);
        DONE = 1'b0;
        REQ  = 4'b0000;
        step(); grant_is("sole_hold1", 2'd2, 4'b0100);
        step(); grant_is("sole_hold2", 2'd2, 4'b0100);
        DONE = 1'b1;
        step();
        chk("sole_release", {31'd0, GNT_VALID}, 32'd0);
        DONE = 1'b0;

        // reset mid-grant: PTR=3, grant 3 then async reset
        REQ = 4'b1000;
        step(); grant_is("pre_rst", 2'd3, 4'b1000);
        #2 RST = 1'b1;
        #1;
        chk("async_rst_gnt",   {28'd0, GNT},       32'd0);
        chk("async_rst_valid", {31'd0, GNT_VALID}, 32'd0);
        chk("async_rst_idx",   {30'd0, GNT_IDX},   32'd0);
        @(negedge CLK);
        RST = 1'b0;
        REQ = 4'b1010;
        step(); grant_is("post_rst", 2'd1, 4'b0010);

        // fresh start for the timeout scenario: grant 0, DONE never comes
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        REQ = 4'b0011;
        step(); grant_is("tmo_start", 2'd0, 4'b0001);
`ifdef GPPCU_ARB_TIMEOUT_EN
        for (int k = 1; k <= 7; k++) begin
            step();
            grant_is("tmo_hold", 2'd0, 4'b0001);
            chk("tmo_hold_pulse", {31'd0, TMO}, 32'd0);
        end
        step();
        grant_is("tmo_next", 2'd1, 4'b0010);
        chk("tmo_pulse", {31'd0, TMO}, 32'd1);
        step();
        grant_is("tmo_after", 2'd1, 4'b0010);
        chk("tmo_pulse_end", {31'd0, TMO}, 32'd0);
`else
        for (int k = 1; k <= 12; k++) begin
            step();
            grant_is("hold_forever", 2'd0, 4'b0001);
            chk("tmo_tied", {31'd0, TMO}, 32'd0);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
